// File: rtl/corr_readout_master.sv
`timescale 1ns/1ps
// corr_readout_master
// Bus master that runs one correlator acquisition and streams out the results.
// It starts the correlator and clears its sample counter, then polls
// Sample_Count until it reaches the latched target. After that it stops the
// correlator, reads the "seen" channel mask, and reads out every flagged
// channel as one beat on a valid/ready result stream.
//
// Parameters
//   POLL_GAP     idle cycles between Sample_Count polls (>= 1)
//   CHANNELS     number of correlator channels scanned (1..32)
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   start, abort      run control (start ignored while busy)
//   target_count      Sample_Count threshold, latched at start
//   addr, Wdata       bus address / write data (zero when there is no access)
//   write, read       single-cycle bus strobes
//   Rdata             combinational read data, valid in the read cycle
//   out_valid/ready   result stream handshake
//   out_chan/data     result channel index and value
//   busy, done        busy outside IDLE; one-cycle completion pulse
module corr_readout_master #(
  parameter int POLL_GAP = 16,
  parameter int CHANNELS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] target_count,
  output logic [31:0] addr,
  output logic [31:0] Wdata,
  output logic        write,
  output logic        read,
  input  logic [31:0] Rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_chan,
  output logic [31:0] out_data,
  output logic        busy,
  output logic        done
);

  localparam logic [31:0] ADDR_RUN  = 32'hfe00_0100;
  localparam logic [31:0] ADDR_CNT  = 32'hfe00_0104;
  localparam logic [31:0] ADDR_SEEN = 32'hfe00_0108;
  localparam logic [31:0] ADDR_DATA = 32'hfe00_0200;
  localparam logic [4:0]  LAST_CH   = 5'(CHANNELS - 1);
  localparam logic [31:0] GAP_LOAD  = 32'(POLL_GAP - 1);

  typedef enum logic [3:0] {
    IDLE, ARM, CLR, WAIT, POLL, STOP, SEEN, SCAN, RD, EMIT, DONE, ABORT
  } state_t;

  state_t      r_state;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_write;
  logic        r_read;
  logic        r_valid;
  logic [4:0]  r_chan;
  logic [31:0] r_data;
  logic        r_busy;
  logic        r_done;
  logic [4:0]  r_ch;
  logic [31:0] r_mask;
  logic [31:0] r_target;
  logic [31:0] r_gap;

  // Outputs are registered so that each one describes the state being
  // entered. The bus access that belongs to a state is therefore presented
  // during that state's cycle, and Rdata can be sampled at the end of it.
  // Strobes, address, write data and done default to zero each cycle, so any
  // access lasts one cycle unless the next state asks for another one.
  // Abort is checked ahead of the case statement so it wins over every normal
  // transition, including an EMIT handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_write  <= 1'b0;
      r_read   <= 1'b0;
      r_valid  <= 1'b0;
      r_chan   <= '0;
      r_data   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_ch     <= '0;
      r_mask   <= '0;
      r_target <= '0;
      r_gap    <= '0;
    end else begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_write <= 1'b0;
      r_read  <= 1'b0;
      r_done  <= 1'b0;
      if (abort && !(r_state inside {IDLE, ABORT, DONE})) begin
        r_state <= ABORT;
        r_write <= 1'b1;
        r_addr  <= ADDR_RUN;
        r_valid <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (start) begin
              r_target <= target_count;
              r_ch     <= '0;
              r_busy   <= 1'b1;
              r_state  <= ARM;
              r_write  <= 1'b1;
              r_addr   <= ADDR_RUN;
              r_wdata  <= 32'd1;
            end
          end
          ARM: begin
            r_state <= CLR;
            r_write <= 1'b1;
            r_addr  <= ADDR_CNT;
          end
          CLR: begin
            r_state <= WAIT;
            r_gap   <= GAP_LOAD;
          end
          WAIT: begin
            if (r_gap == 32'd0) begin
              r_state <= POLL;
              r_read  <= 1'b1;
              r_addr  <= ADDR_CNT;
            end else begin
              r_gap <= r_gap - 32'd1;
            end
          end
          POLL: begin
            if (Rdata >= r_target) begin
              r_state <= STOP;
              r_write <= 1'b1;
              r_addr  <= ADDR_RUN;
            end else begin
              r_state <= WAIT;
              r_gap   <= GAP_LOAD;
            end
          end
          STOP: begin
            r_state <= SEEN;
            r_read  <= 1'b1;
            r_addr  <= ADDR_SEEN;
          end
          SEEN: begin
            r_mask  <= Rdata;
            r_state <= SCAN;
          end
          // Each channel has its own 16-byte result slot.
          SCAN: begin
            if (r_mask[r_ch]) begin
              r_state <= RD;
              r_read  <= 1'b1;
              r_addr  <= ADDR_DATA + {23'd0, r_ch, 4'd0};
            end else if (r_ch == LAST_CH) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_ch <= r_ch + 5'd1;
            end
          end
          RD: begin
            r_data  <= Rdata;
            r_chan  <= r_ch;
            r_valid <= 1'b1;
            r_state <= EMIT;
          end
          EMIT: begin
            if (out_ready) begin
              r_valid <= 1'b0;
              if (r_ch == LAST_CH) begin
                r_state <= DONE;
                r_done  <= 1'b1;
              end else begin
                r_ch    <= r_ch + 5'd1;
                r_state <= SCAN;
              end
            end
          end
          DONE: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
          ABORT: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  assign addr      = r_addr;
  assign Wdata     = r_wdata;
  assign write     = r_write;
  assign read      = r_read;
  assign out_valid = r_valid;
  assign out_chan  = r_chan;
  assign out_data  = r_data;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: doc/corr_readout_master.md
CORR_READOUT_MASTER -- requirements
Module: corr_readout_master

Interface
REQ-001 SHALL have parameter POLL_GAP, default 16: idle cycles between Sample_Count polls (minimum 1).
REQ-002 SHALL have parameter CHANNELS, default 32: number of correlator channels scanned (1..32).
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port start, input, 1: one-cycle pulse that begins an acquisition run; ignored unless busy=0.
REQ-006 SHALL have port abort, input, 1: terminates the run in progress.
REQ-007 SHALL have port target_count, input, 32: Sample_Count threshold, latched at start.
REQ-008 SHALL have port addr, output, 32: bus address.
REQ-009 SHALL have port Wdata, output, 32: bus write data.
REQ-010 SHALL have ports write and read, output, 1 each: single-cycle bus strobes, never both high.
REQ-011 SHALL have port Rdata, input, 32: combinational responder read data, valid in the same cycle as read.
REQ-012 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_chan (output, 5), out_data (output, 32): result stream.
REQ-013 SHALL have ports busy (output, 1) and done (output, 1): busy is high in every state except IDLE; done is a one-cycle completion pulse.

Function
REQ-014 SHALL have FSM states IDLE, ARM, CLR, WAIT, POLL, STOP, SEEN, SCAN, RD, EMIT, DONE, ABORT.
REQ-015 SHALL drive addr=0, Wdata=0, read=0, write=0 in every state that performs no bus access.
REQ-016 SHALL, in IDLE on start=1, latch target_count, clear ch to 0, and go to ARM.
REQ-017 SHALL, in ARM, write addr=32'hfe00_0100, Wdata=1 (Global_Run=1), then go to CLR.
REQ-018 SHALL, in CLR, write addr=32'hfe00_0104, Wdata=0 (Sample_Count=0), then go to WAIT with the gap counter loaded to POLL_GAP-1.
REQ-019 SHALL, in WAIT, decrement the gap counter each cycle and go to POLL in the cycle after it reads 0.
REQ-020 SHALL, in POLL, read addr=32'hfe00_0104; if the unsigned Rdata is >= the latched target, go to STOP, else reload the gap counter and go to WAIT.
REQ-021 SHALL, in STOP, write addr=32'hfe00_0100, Wdata=0, then go to SEEN.
REQ-022 SHALL, in SEEN, read addr=32'hfe00_0108, latch Rdata into mask[31:0], then go to SCAN.
REQ-023 SHALL, in SCAN, spend one cycle per channel: if mask[ch]=1, go to RD; else if ch=CHANNELS-1, go to DONE; else increment ch.
REQ-024 SHALL, in RD, read addr=32'hfe00_0200 + (ch<<4), latch Rdata into out_data and ch into out_chan, then go to EMIT.
REQ-025 SHALL, in EMIT, hold out_valid=1 with out_data and out_chan stable until out_ready=1; on that handshake cycle go to DONE if ch=CHANNELS-1, else increment ch and go to SCAN.
REQ-026 SHALL keep out_valid=0 in every state other than EMIT; out_ready is ignored outside EMIT.
REQ-027 SHALL, in DONE, pulse done=1 for one cycle, then go to IDLE.
REQ-028 SHALL, on abort=1 in any state except IDLE, ABORT, or DONE, go to ABORT on the next edge; the bus access of that cycle still completes.
REQ-029 SHALL, in ABORT, write addr=32'hfe00_0100, Wdata=0, then go to IDLE with no done pulse and with out_valid dropped.
REQ-030 SHALL give abort priority over every normal transition in the same cycle, including an EMIT handshake.
REQ-031 SHALL, when target=0, satisfy the first POLL and go to STOP.
REQ-032 SHALL, when mask=0, produce no stream beats and reach DONE after CHANNELS SCAN cycles.
REQ-033 SHALL ignore start while busy=1.

Reset
REQ-034 SHALL, while rst=1 (asynchronously), force state=IDLE; addr, Wdata, read, write, out_valid, out_chan, out_data, busy, done, ch, mask, the latched target, and the gap counter all to 0.
REQ-035 SHALL, on reset mid-run, drop all bus strobes immediately without issuing a Global_Run=0 write; a new start is accepted on the first edge after rst falls.

Verification
REQ-036 SHALL cover: POLL_GAP=4, target=3, responder counts 0,1,2,3 on successive polls -> exactly one write 0100/1, one write 0104/0, four reads of 0104 spaced 5 cycles apart, write 0100/0, read 0108.
REQ-037 SHALL cover: mask=32'h8000_0005, out_ready held 1 -> three beats with chan 0,2,31 from addresses fe00_0200, fe00_0220, fe00_03f0, then a single done pulse.
REQ-038 SHALL cover: out_ready=0 for 7 cycles in EMIT -> out_valid, out_chan, and out_data stable for all 7 cycles, with no bus activity.
REQ-039 SHALL cover: target=0, mask=0 -> no beats; done asserted exactly CHANNELS cycles after the SEEN cycle plus one.
REQ-040 SHALL cover: abort asserted in WAIT, and separately in EMIT -> next access is write 0100/0, then IDLE, with done never asserted.
REQ-041 SHALL cover: rst pulsed mid-SCAN, then start issued -> all outputs 0 during reset and a fresh run beginning with write 0100/1.
